// File: rtl/shop_pkg.sv
// Shared constants for the shop command front end and the shop FSM:
// character codes, assembler state encoding and the common field widths.
package shop_pkg;

  localparam int SHOP_NUM_CHARS  = 7;
  localparam int SHOP_U_NUM_BITS = 4;

  localparam logic [7:0] CHR_BS       = 8'h08;
  localparam logic [7:0] CHR_CR       = 8'h0D;
  localparam logic [7:0] CHR_ESC      = 8'h1B;
  localparam logic [7:0] CHR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DISCARD = 1'b1
  } asm_state_e;

  typedef struct packed {
    logic printable;
    logic bs;
    logic cr;
    logic esc;
    logic other;
  } char_class_t;

endpackage

// File: rtl/shop_char_class.sv
// Combinational classification of one ASCII character into exactly one
// of printable / backspace / enter / escape / other.
module shop_char_class
  import shop_pkg::*;
(
  input  logic [7:0]  i_char,
  output char_class_t o_class
);

  // one-hot decode; anything outside the known classes lands in other
  always_comb begin
    o_class = '0;
    if (i_char == CHR_BS) begin
      o_class.bs = 1'b1;
    end else if (i_char == CHR_CR) begin
      o_class.cr = 1'b1;
    end else if (i_char == CHR_ESC) begin
      o_class.esc = 1'b1;
    end else if ((i_char >= CHR_PRINT_LO) && (i_char <= CHR_PRINT_HI)) begin
      o_class.printable = 1'b1;
    end else begin
      o_class.other = 1'b1;
    end
  end

endmodule

// File: rtl/shop_cmd_assembler.sv
// Line editor: assembles a serial ASCII stream into a right-justified
// command word and presents it with a one-cycle o_rdy strobe.
module shop_cmd_assembler
  import shop_pkg::*;
#(
  parameter int NUM_CHARS  = SHOP_NUM_CHARS,
  parameter int U_NUM_BITS = SHOP_U_NUM_BITS
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_valid,
  input  logic [7:0]                         i_char,
  input  logic [U_NUM_BITS-1:0]              i_u_sw,
  output logic                               o_rdy,
  output logic [U_NUM_BITS-1:0]              o_u,
  output logic [NUM_CHARS*8-1:0]             o_a,
  output logic                               o_ovf,
  output logic [$clog2(NUM_CHARS+1)-1:0]     o_len
);

  localparam int LEN_W = $clog2(NUM_CHARS + 1);
  localparam int BUF_W = NUM_CHARS * 8;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(NUM_CHARS);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  asm_state_e        state_r, state_nxt_s;
  logic [BUF_W-1:0]  buf_r, buf_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic              commit_s;
  logic              ovf_s;
  char_class_t       cls_s;

  shop_char_class u_char_class (
    .i_char  (i_char),
    .o_class (cls_s)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state: overflow enters DISCARD, only Enter leaves it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (ovf_s) begin
          state_nxt_s = ST_DISCARD;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (i_valid && cls_s.cr) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: state_nxt_s = ST_COLLECT;
    endcase
  end

  // line-edit decisions; DISCARD and ignored characters leave everything as is
  always_comb begin
    buf_nxt_s = buf_r;
    len_nxt_s = len_r;
    commit_s  = 1'b0;
    ovf_s     = 1'b0;
    if (!i_valid || cls_s.other || (state_r != ST_COLLECT)) begin
      buf_nxt_s = buf_r;
    end else if (cls_s.printable) begin
      if (len_r < LEN_FULL) begin
        buf_nxt_s = {buf_r[BUF_W-9:0], i_char};
        len_nxt_s = len_r + LEN_ONE;
      end else begin
        ovf_s     = 1'b1;
        buf_nxt_s = '0;
        len_nxt_s = LEN_ZERO;
      end
    end else if (cls_s.bs) begin
      if (len_r != LEN_ZERO) begin
        buf_nxt_s = buf_r >> 4'd8;
        len_nxt_s = len_r - LEN_ONE;
      end else begin
        len_nxt_s = len_r;
      end
    end else if (cls_s.esc) begin
      buf_nxt_s = '0;
      len_nxt_s = LEN_ZERO;
    end else if (cls_s.cr) begin
      if (len_r != LEN_ZERO) begin
        commit_s  = 1'b1;
        buf_nxt_s = '0;
        len_nxt_s = LEN_ZERO;
      end else begin
        commit_s  = 1'b0;
      end
    end else begin
      buf_nxt_s = buf_r;
    end
  end

  // working registers and registered outputs; o_a/o_u change only on commit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_r <= '0;
      len_r <= LEN_ZERO;
      o_a   <= '0;
      o_u   <= '0;
      o_rdy <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      buf_r <= buf_nxt_s;
      len_r <= len_nxt_s;
      o_rdy <= commit_s;
      o_ovf <= ovf_s;
      if (commit_s) begin
        o_a <= buf_r;
        o_u <= i_u_sw;
      end else begin
        o_a <= o_a;
        o_u <= o_u;
      end
    end
  end

  assign o_len = len_r;

endmodule

// File: tb/tb_shop_cmd_assembler.sv
// Self-checking bench: directed line-editing scenarios plus random traffic,
// all compared every cycle against a queue-based model of the line editor.
module tb_shop_cmd_assembler;

  localparam int NC = 7;
  localparam int UB = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_valid = 1'b0;
  logic [7:0]    i_char = 8'h00;
  logic [UB-1:0] i_u_sw = '0;
  logic          o_rdy;
  logic [UB-1:0] o_u;
  logic [NC*8-1:0] o_a;
  logic          o_ovf;
  logic [2:0]    o_len;

  shop_cmd_assembler #(.NUM_CHARS(NC), .U_NUM_BITS(UB)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_char  (i_char),
    .i_u_sw  (i_u_sw),
    .o_rdy   (o_rdy),
    .o_u     (o_u),
    .o_a     (o_a),
    .o_ovf   (o_ovf),
    .o_len   (o_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // behavioural model: the line is a queue of characters
  logic [7:0]      line_q[$];
  bit              discarding = 1'b0;
  logic [NC*8-1:0] exp_a   = '0;
  logic [UB-1:0]   exp_u   = '0;
  logic            exp_rdy = 1'b0;
  logic            exp_ovf = 1'b0;
  int              exp_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit vld, input logic [7:0] ch, input logic [UB-1:0] sw);
    logic [NC*8-1:0] word;
    exp_rdy = 1'b0;
    exp_ovf = 1'b0;
    if (rst) begin
      line_q.delete();
      discarding = 1'b0;
      exp_a = '0;
      exp_u = '0;
    end else if (vld) begin
      if (discarding) begin
        if (ch == 8'h0D) discarding = 1'b0;
      end else if (ch >= 8'h20 && ch <= 8'h7E) begin
        if (line_q.size() < NC) begin
          line_q.push_back(ch);
        end else begin
          exp_ovf = 1'b1;
          line_q.delete();
          discarding = 1'b1;
        end
      end else if (ch == 8'h08) begin
        if (line_q.size() > 0) void'(line_q.pop_back());
      end else if (ch == 8'h1B) begin
        line_q.delete();
      end else if (ch == 8'h0D) begin
        if (line_q.size() > 0) begin
          word = '0;
          foreach (line_q[k]) word = word * 256 + (NC*8)'(line_q[k]);
          exp_a   = word;
          exp_u   = sw;
          exp_rdy = 1'b1;
          line_q.delete();
        end
      end
    end
    exp_len = line_q.size();
  endtask

  // one clock: drive inputs, let the edge pass, advance the model, settle
  task automatic step(input bit rst, input bit vld, input logic [7:0] ch, input logic [UB-1:0] sw);
    i_reset = rst;
    i_valid = vld;
    i_char  = ch;
    i_u_sw  = sw;
    @(posedge clk);
    model_step(rst, vld, ch, sw);
    #1;
  endtask

  task automatic type_str(input string s, input logic [UB-1:0] sw);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i], sw);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("rdy", 64'(o_rdy), 64'(exp_rdy));
      check("ovf", 64'(o_ovf), 64'(exp_ovf));
      check("len", 64'(o_len), 64'(exp_len));
      check("a",   64'(o_a),   64'(exp_a));
      check("u",   64'(o_u),   64'(exp_u));
    end
  end

  initial begin
    int r;
    logic [7:0] ch;
    step(1'b1, 1'b0, 8'h00, 4'h0);
    step(1'b1, 1'b1, 8'h41, 4'h0);
    check_en = 1'b1;
    check("reset_a",   64'(o_a),   64'h0);
    check("reset_rdy", 64'(o_rdy), 64'h0);
    check("reset_len", 64'(o_len), 64'h0);

    // Login with switch 3
    type_str("Login", 4'h3);
    step(1'b0, 1'b1, 8'h0D, 4'h3);
    check("login_rdy", 64'(o_rdy), 64'h1);
    check("login_a",   64'(o_a),   64'h00_00_4C_6F_67_69_6E);
    check("login_u",   64'(o_u),   64'h3);
    step(1'b0, 1'b0, 8'h00, 4'h9);
    check("login_rdy_drop", 64'(o_rdy), 64'h0);
    check("login_a_hold",   64'(o_a),   64'h00_00_4C_6F_67_69_6E);

    // backspace editing
    type_str("Adx", 4'h1);
    step(1'b0, 1'b1, 8'h08, 4'h1);
    type_str("m", 4'h1);
    step(1'b0, 1'b1, 8'h0D, 4'h1);
    check("adm_a", 64'(o_a), 64'h00_00_00_00_41_64_6D);
    step(1'b0, 1'b1, 8'h08, 4'h1);
    check("bs_empty_len", 64'(o_len), 64'h0);

    // overflow and discard
    type_str("AddItem", 4'h2);
    step(1'b0, 1'b1, 8'h58, 4'h2);
    check("ovf_pulse", 64'(o_ovf), 64'h1);
    type_str("Buy", 4'h2);
    step(1'b0, 1'b1, 8'h0D, 4'h2);
    check("discard_cr_rdy", 64'(o_rdy), 64'h0);
    check("discard_cr_a",   64'(o_a),   64'h00_00_00_00_41_64_6D);
    type_str("Buy", 4'h5);
    step(1'b0, 1'b1, 8'h0D, 4'h5);
    check("buy_a", 64'(o_a), 64'h00_00_00_00_42_75_79);

    // exactly full line, then empty Enter
    type_str("AddItem", 4'h7);
    step(1'b0, 1'b1, 8'h0D, 4'h7);
    check("full_a",   64'(o_a),   64'h41_64_64_49_74_65_6D);
    check("full_ovf", 64'(o_ovf), 64'h0);
    step(1'b0, 1'b1, 8'h0D, 4'h7);
    check("empty_cr_rdy", 64'(o_rdy), 64'h0);

    // escape, then reset mid-line
    type_str("Log", 4'h4);
    step(1'b0, 1'b1, 8'h1B, 4'h4);
    type_str("Buy", 4'h4);
    step(1'b0, 1'b1, 8'h0D, 4'h4);
    check("esc_buy_a", 64'(o_a), 64'h00_00_00_00_42_75_79);
    type_str("Log", 4'h4);
    step(1'b1, 1'b1, 8'h41, 4'h4);
    step(1'b0, 1'b1, 8'h0D, 4'h4);
    check("rst_mid_rdy", 64'(o_rdy), 64'h0);
    check("rst_mid_a",   64'(o_a),   64'h0);

    // Enter immediately followed by a character
    type_str("A", 4'h6);
    step(1'b0, 1'b1, 8'h0D, 4'h6);
    check("b2b_rdy", 64'(o_rdy), 64'h1);
    step(1'b0, 1'b1, 8'h42, 4'h6);
    check("b2b_len", 64'(o_len), 64'h1);
    check("b2b_rdy_low", 64'(o_rdy), 64'h0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      ch = 8'($urandom_range(32'h20, 32'h7E));
      else if (r < 65) ch = 8'h08;
      else if (r < 70) ch = 8'h1B;
      else if (r < 85) ch = 8'h0D;
      else if (r < 90) ch = 8'h0A;
      else             ch = 8'($urandom_range(0, 255));
      step((($urandom_range(0, 199)) == 0), (($urandom_range(0, 9)) != 0),
           ch, UB'($urandom_range(0, 15)));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shop_cmd_assembler.md
# shop_cmd_assembler

Upstream front end for `shop_v`: collects a serial stream of ASCII characters (keyboard/UART receiver output) into one right-justified command word, then presents it to the shop FSM. Presentation is a stable `o_a`/`o_u` pair plus a one-cycle `o_rdy` strobe. Line editing is supported: backspace, escape-to-clear, and overflow discard. The output word uses the same packing as a Verilog string literal, so a typed `Login` compares equal to `CMD_KEY__LOGIN`.

## Interface
Parameters:
- `NUM_CHARS`, 7, maximum characters per line. Must equal the shop's `I_A_NUM_ASCII_CHARS`.
- `U_NUM_BITS`, 4, width of the user/quantity field. Must equal `I_U_NUM_BITS`.

Ports:
- `i_clk` in 1: the single clock. All logic updates on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_valid` in 1: `i_char` is valid this cycle. Accepted every cycle, no backpressure.
- `i_char` in 8: ASCII character.
- `i_u_sw` in `U_NUM_BITS`: switch value, sampled at commit.
- `o_rdy` out 1: one-cycle strobe meaning `o_a`/`o_u` hold a new command. Connects to the shop's `i_rdy`.
- `o_u` out `U_NUM_BITS`: sampled `i_u_sw`. Connects to the shop's `i_u`.
- `o_a` out `NUM_CHARS*8`: committed line, right-justified, zero-padded on the left. Connects to the shop's `i_a`.
- `o_ovf` out 1: one-cycle strobe when a line overflows.
- `o_len` out `$clog2(NUM_CHARS+1)`: characters currently buffered, for display.

## Operation
- State register has two states: `COLLECT` and `DISCARD`. Working registers:
  - `buf`, `NUM_CHARS*8` bits
  - `len`
- Character classes:
  - Printable: 0x20–0x7E.
  - Backspace: 0x08.
  - Enter: 0x0D.
  - Escape: 0x1B.
  - All others, including 0x0A, are ignored with no state change.
- `COLLECT` behaviour:
  - Printable with `len < NUM_CHARS`: `buf <= {buf[(NUM_CHARS-1)*8-1:0], i_char}`, `len+1`.
  - Printable with `len == NUM_CHARS`: pulse `o_ovf`, clear `buf`/`len`, go to `DISCARD`.
  - Backspace with `len > 0`: `buf <= buf >> 8`, `len-1`. With `len == 0` it is ignored.
  - Escape: clear `buf`/`len`.
  - Enter with `len > 0` commits:
    - `o_a <= buf`
    - `o_u <= i_u_sw`
    - `o_rdy <= 1`
    - clear `buf`/`len`
  - Enter with `len == 0` is ignored: no strobe, `o_a` unchanged.
- `DISCARD` behaviour:
  - All characters are dropped, including backspace and escape.
  - Enter returns to `COLLECT`, with no commit and no strobe.
- `o_a` and `o_u` hold their last committed value until the next commit. They are never cleared except by reset.
- Reset values:
  - `o_a = 0`, `o_u = 0`, `o_rdy = 0`, `o_ovf = 0`, `o_len = 0`
  - state = `COLLECT`, `buf = 0`
- Reset mid-line discards the partial line. Reset has priority over `i_valid` in the same cycle.

## Timing
- Latency: Enter sampled at edge N makes `o_rdy = 1` and new `o_a`/`o_u` visible after edge N, for exactly one cycle.
- `o_a`/`o_u` are stable in the cycle `o_rdy` is high and after it.
- A character accepted at edge N+1, directly after Enter, starts the next line normally. There is no dead cycle.
- Back-to-back lines are allowed at a rate of one character per cycle. The downstream shop must sample on `o_rdy`.
- `o_ovf` is high for exactly the one cycle after the overflowing character's edge.
- `o_len` is registered and reflects edits one cycle after each accepted character.
- `i_u_sw` is sampled only at the commit edge. Changes between commits have no effect.

## Structure
- Package `shop_pkg` holds:
  - the character constants `CHR_BS`, `CHR_CR`, `CHR_ESC`, `CHR_PRINT_LO`, `CHR_PRINT_HI`
  - the state encoding
  - the shared `NUM_CHARS` and `U_NUM_BITS` defaults, so this block and `shop_v` cannot disagree
- One natural sub-module, `shop_char_class`: combinational classification of `i_char` into `{printable, bs, cr, esc, other}`. Everything else lives in `shop_cmd_assembler`. Expected size is about 150–250 lines.

## Test plan
- Reset, then "Login", 0x0D with `i_u_sw = 4'h3`: one `o_rdy` pulse, `o_a = 56'h00_00_4C_6F_67_69_6E`, `o_u = 3`. `o_a` is held after the pulse.
- "Adx", BS, "m", CR: `o_a = 56'h00_00_00_00_41_64_6D` ("Adm"). BS on an empty line leaves `o_len = 0`.
- Overflow, "AddItemX" (8 chars):
  - `o_ovf` pulses on the X.
  - The following "Buy" is dropped.
  - CR gives no `o_rdy`, and `o_a` keeps its previous value.
  - Next "Buy", CR commits `56'h00_00_00_00_42_75_79`.
- Exactly 7 chars "AddItem", CR: commits `56'h41_64_64_49_74_65_6D` with no `o_ovf`. CR on an empty line produces no strobe.
- "Log", ESC, "Buy", CR: commits "Buy". Separately, "Log" then `i_reset` for one cycle, then CR: no strobe, and `o_a = 0`.
- CR followed by "B" on the very next cycle: `o_rdy` and `o_len = 1` are each observed correctly, with no lost character.
